// File: rtl/fifo_burst_sched.sv
// fifo_burst_sched: drains an attached synchronous FIFO into a burst write
// interface. A transfer of i_len beats is cut into bursts of at most
// 2^LGMAXBURST beats; a burst is only issued once the FIFO already holds
// all of its beats, and only one burst is outstanding at a time.
module fifo_burst_sched #(
    parameter int unsigned BW         = 32,
    parameter int unsigned LGFLEN     = 4,
    parameter int unsigned AW         = 32,
    parameter int unsigned LGMAXBURST = 4
) (
    input  logic            i_clk,
    input  logic            i_reset_n,
    input  logic            i_start,
    input  logic [AW-1:0]   i_addr,
    input  logic [15:0]     i_len,
    input  logic [LGFLEN:0] i_fifo_fill,
    input  logic            i_fifo_empty,
    output logic            o_fifo_rd,
    output logic            o_awvalid,
    input  logic            i_awready,
    output logic [AW-1:0]   o_awaddr,
    output logic [7:0]      o_awlen,
    output logic            o_wvalid,
    input  logic            i_wready,
    output logic            o_wlast,
    input  logic            i_bvalid,
    input  logic [1:0]      i_bresp,
    output logic            o_bready,
    output logic            o_busy,
    output logic            o_done,
    output logic            o_err
);

    localparam int unsigned MAXB   = 1 << LGMAXBURST;
    localparam int unsigned BSHIFT = $clog2(BW / 8);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT,
        ST_ADDR,
        ST_DATA,
        ST_RESP
    } state_t;

    state_t        state;
    state_t        state_nx;
    logic [AW-1:0] addr;
    logic [15:0]   rem;
    logic [7:0]    beat;
    logic          err;
    logic          done;

    logic [16:0]   blen;
    logic          fill_ok;
    logic          last_beat;
    logic          last_burst;
    logic          bresp_err;

    // Burst length and the conditions derived from it; rem is stable from
    // WAIT through RESP, so blen needs no register of its own.
    always_comb begin
        if (rem >= 16'(MAXB)) begin
            blen = 17'(MAXB);
        end else begin
            blen = {1'b0, rem};
        end
        fill_ok    = (17'(i_fifo_fill) >= blen);
        last_beat  = (17'(beat) == (blen - 17'd1));
        last_burst = ({1'b0, rem} == blen);
        bresp_err  = (i_bresp == 2'b10) || (i_bresp == 2'b11);
    end

    // State register.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE: if (i_start && (i_len != '0)) state_nx = ST_WAIT;
            ST_WAIT: if (fill_ok) state_nx = ST_ADDR;
            ST_ADDR: if (i_awready) state_nx = ST_DATA;
            ST_DATA: if (o_fifo_rd && last_beat) state_nx = ST_RESP;
            ST_RESP: if (i_bvalid) state_nx = last_burst ? ST_IDLE : ST_WAIT;
            default: state_nx = ST_IDLE;
        endcase
    end

    // Output decode from the current state.
    always_comb begin
        o_awvalid = (state == ST_ADDR);
        o_awaddr  = addr;
        o_awlen   = 8'(blen - 17'd1);
        o_wvalid  = (state == ST_DATA) && !i_fifo_empty;
        o_fifo_rd = o_wvalid && i_wready;
        o_wlast   = (state == ST_DATA) && last_beat;
        o_bready  = (state == ST_RESP);
        o_busy    = (state != ST_IDLE);
        o_done    = done;
        o_err     = err;
    end

    // Address, remaining-beat and beat counters, sticky error, done pulse.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            addr <= '0;
            rem  <= '0;
            beat <= '0;
            err  <= 1'b0;
            done <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (i_start) begin
                        addr <= i_addr;
                        rem  <= i_len;
                        err  <= 1'b0;
                        done <= (i_len == '0);
                    end
                end
                ST_ADDR: beat <= '0;
                ST_DATA: begin
                    if (o_fifo_rd) beat <= beat + 8'd1;
                end
                ST_RESP: begin
                    if (i_bvalid) begin
                        if (bresp_err) err <= 1'b1;
                        addr <= addr + (AW'(blen) << BSHIFT);
                        rem  <= rem - blen[15:0];
                        done <= last_burst;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
